// File: rtl/rng_pkg.sv
// Shared types and helpers for the random-number server: the xorshift32
// step function, the default seed, zero-seed substitution and the FSM enum.
package rng_pkg;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic {
        WARM  = 1'b0,
        READY = 1'b1
    } fsm_t;

    // One xorshift32 step with shift constants 13/17/5, 32-bit truncating.
    function automatic logic [31:0] xs_step(input logic [31:0] s);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        a = s ^ (s << 5'd13);
        b = a ^ (a >> 5'd17);
        c = b ^ (b << 5'd5);
        return c;
    endfunction

    // An all-zero state would lock xorshift at zero forever, so it becomes 1.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        logic [31:0] r;
        if (s == 32'h0000_0000) begin
            r = DEFAULT_SEED;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester
// strictly after the pointer position, wrapping around. The pointer itself
// is held by the parent.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_vld
);

    logic [W-1:0] cand_s;

    // Scan requesters ptr+1, ptr+2, ... ptr (mod N) and take the first one set.
    always_comb begin
        grant     = {N{1'b0}};
        grant_idx = {W{1'b0}};
        grant_vld = 1'b0;
        cand_s    = {W{1'b0}};
        for (int i = 1; i <= N; i++) begin
            cand_s = W'((int'(ptr) + i) % N);
            if (!grant_vld && eligible[cand_s]) begin
                grant_vld        = 1'b1;
                grant[cand_s]    = 1'b1;
                grant_idx        = cand_s;
            end else begin
                grant_vld = grant_vld;
            end
        end
    end

endmodule

// File: rtl/rng_server.sv
// Shared random-number server: one xorshift32 generator handing out the low
// 16 bits of each new state to round-robin-arbitrated requesters. The
// generator advances only on a grant (or during warm-up), so every consumer
// sees a sequence fixed by the seed and the request order.
module rng_server
    import rng_pkg::*;
#(
    parameter int          N_REQ  = 4,
    parameter logic [31:0] SEED   = 32'h0000_0001,
    parameter int          WARMUP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [15:0]      rnd_data,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    output logic             busy
);

    localparam int          PW        = $clog2(N_REQ);
    localparam logic [7:0]  WARM_CNT  = 8'(WARMUP);
    localparam fsm_t        FSM_LOAD  = (WARMUP > 0) ? WARM : READY;
    localparam logic [PW-1:0] PTR_INIT = PW'(N_REQ - 1);

    fsm_t             fsm_r;
    fsm_t             fsm_nxt_s;
    logic [31:0]      state_r;
    logic [31:0]      step_s;
    logic [7:0]       cnt_r;
    logic [N_REQ-1:0] ack_r;
    logic [15:0]      rnd_r;
    logic [PW-1:0]    ptr_r;
    logic [N_REQ-1:0] elig_s;
    logic [N_REQ-1:0] grant_s;
    logic [PW-1:0]    gidx_s;
    logic             gvld_s;
    logic             serve_s;
    logic             busy_s;

    assign step_s   = xs_step(state_r);
    // A requester acked this cycle sits out one cycle.
    assign elig_s   = req & ~ack_r;
    assign ack      = ack_r;
    assign rnd_data = rnd_r;
    assign busy     = busy_s;

    rr_arbiter #(
        .N (N_REQ),
        .W (PW)
    ) u_arb (
        .eligible  (elig_s),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (gidx_s),
        .grant_vld (gvld_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r <= FSM_LOAD;
        end else begin
            fsm_r <= fsm_nxt_s;
        end
    end

    // FSM next state: seed load restarts warm-up; warm-up ends on its last step.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            WARM: begin
                if (seed_load) begin
                    fsm_nxt_s = FSM_LOAD;
                end else if (cnt_r <= 8'd1) begin
                    fsm_nxt_s = READY;
                end else begin
                    fsm_nxt_s = WARM;
                end
            end
            READY: begin
                if (seed_load) begin
                    fsm_nxt_s = FSM_LOAD;
                end else begin
                    fsm_nxt_s = READY;
                end
            end
            default: fsm_nxt_s = READY;
        endcase
    end

    // FSM outputs: busy during warm-up, serve only when ready with a winner.
    always_comb begin
        busy_s  = 1'b0;
        serve_s = 1'b0;
        if (fsm_r == WARM) begin
            busy_s = 1'b1;
        end else begin
            serve_s = gvld_s && !seed_load;
        end
    end

    // Generator, warm counter, grant pulse, output word and RR pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= fix_seed(SEED);
            cnt_r   <= WARM_CNT;
            ack_r   <= {N_REQ{1'b0}};
            rnd_r   <= 16'h0000;
            ptr_r   <= PTR_INIT;
        end else if (seed_load) begin
            state_r <= fix_seed(seed_in);
            cnt_r   <= WARM_CNT;
            ack_r   <= {N_REQ{1'b0}};
        end else if (fsm_r == WARM) begin
            state_r <= step_s;
            cnt_r   <= cnt_r - 8'd1;
            ack_r   <= {N_REQ{1'b0}};
        end else if (serve_s) begin
            state_r <= step_s;
            ack_r   <= grant_s;
            rnd_r   <= step_s[15:0];
            ptr_r   <= gidx_s;
        end else begin
            ack_r   <= {N_REQ{1'b0}};
        end
    end

endmodule

// File: tb/tb_rng_server.sv
// Self-checking bench for rng_server. Two instances (WARMUP=0 and WARMUP=2)
// share one stimulus stream; a behavioural model pushes the expected outputs
// of each cycle into per-instance queues when the stimulus is driven, and
// they are popped and compared one time unit after the clock edge.
module tb_rng_server;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        seed_load;
    logic [31:0] seed_in;
    logic [3:0]  ack0, ack1;
    logic [15:0] rnd0, rnd1;
    logic        busy0, busy1;

    always #5 clk = ~clk;

    rng_server #(.N_REQ(4), .SEED(32'h0000_0001), .WARMUP(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .ack(ack0), .rnd_data(rnd0),
        .seed_load(seed_load), .seed_in(seed_in), .busy(busy0)
    );

    rng_server #(.N_REQ(4), .SEED(32'h0000_0001), .WARMUP(2)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .ack(ack1), .rnd_data(rnd1),
        .seed_load(seed_load), .seed_in(seed_in), .busy(busy1)
    );

    typedef struct {
        logic [3:0]  ack;
        logic [15:0] rnd;
        logic        busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec;
    int n_err;

    // Behavioural model state, index 0 = WARMUP 0, index 1 = WARMUP 2.
    logic [31:0] m_state [2];
    int          m_cnt   [2];
    bit          m_warm  [2];
    logic [3:0]  m_ack   [2];
    logic [15:0] m_rnd   [2];
    int          m_ptr   [2];
    int          warm_p  [2];
    logic [3:0]  seen0;

    function automatic logic [31:0] xs(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 32'h0000_0001;
            m_cnt[k]   = warm_p[k];
            m_warm[k]  = (warm_p[k] > 0);
            m_ack[k]   = 4'b0000;
            m_rnd[k]   = 16'h0000;
            m_ptr[k]   = 3;
        end
    endtask

    task automatic model_step(input int k);
        logic [3:0] elig;
        int         g;
        exp_t       e;
        if (seed_load) begin
            m_state[k] = (seed_in == 32'h0) ? 32'h0000_0001 : seed_in;
            m_cnt[k]   = warm_p[k];
            m_warm[k]  = (warm_p[k] > 0);
            m_ack[k]   = 4'b0000;
        end else if (m_warm[k]) begin
            m_state[k] = xs(m_state[k]);
            if (m_cnt[k] == 1) m_warm[k] = 1'b0;
            m_cnt[k]   = m_cnt[k] - 1;
            m_ack[k]   = 4'b0000;
        end else begin
            elig = req & ~m_ack[k];
            if (elig != 4'b0000) begin
                g = m_ptr[k];
                do begin
                    g = (g + 1) % 4;
                end while (((elig >> g) & 4'b0001) == 4'b0000);
                m_ack[k]   = 4'b0001 << g;
                m_state[k] = xs(m_state[k]);
                m_rnd[k]   = m_state[k][15:0];
                m_ptr[k]   = g;
            end else begin
                m_ack[k]   = 4'b0000;
            end
        end
        e.ack  = m_ack[k];
        e.rnd  = m_rnd[k];
        e.busy = m_warm[k];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Predict this cycle, let the edge happen, then compare both instances.
    task automatic tick();
        exp_t e;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        seen0 = seen0 | ack0;
        e = q0.pop_front();
        chk("ack0",  32'(ack0),  32'(e.ack));
        chk("rnd0",  32'(rnd0),  32'(e.rnd));
        chk("busy0", 32'(busy0), 32'(e.busy));
        e = q1.pop_front();
        chk("ack1",  32'(ack1),  32'(e.ack));
        chk("rnd1",  32'(rnd1),  32'(e.rnd));
        chk("busy1", 32'(busy1), 32'(e.busy));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 4'b0000;
        seed_load = 1'b0;
        seed_in   = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_ack0",  32'(ack0),  32'h0);
        chk("rst_rnd0",  32'(rnd0),  32'h0);
        chk("rst_busy0", 32'(busy0), 32'h0);
        chk("rst_ack1",  32'(ack1),  32'h0);
        chk("rst_busy1", 32'(busy1), 32'h1);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] s3;
        n_vec     = 0;
        n_err     = 0;
        seen0     = 4'b0000;
        warm_p[0] = 0;
        warm_p[1] = 2;
        s3        = xs(xs(xs(32'h0000_0001)));

        // Single persistent requester: every other cycle, known first words.
        do_reset();
        req = 4'b0001;
        tick();
        chk("A_ack1", 32'(ack0), 32'h1);
        chk("A_d1",   32'(rnd0), 32'h2021);
        tick();
        chk("A_gap",  32'(ack0), 32'h0);
        tick();
        chk("A_ack2", 32'(ack0), 32'h1);
        chk("A_d2",   32'(rnd0), 32'h0601);

        // All four requesting: back-to-back grants in order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("B_order", 32'(ack0), 32'(4'b0001 << (i % 4)));
            if (i == 0) chk("B_d1", 32'(rnd0), 32'h2021);
            if (i == 1) chk("B_d2", 32'(rnd0), 32'h0601);
        end

        // Warm-up instance: busy for two cycles, then step^3(1) as first word.
        do_reset();
        req = 4'b0010;
        tick();
        chk("C_busy_a", 32'(busy1), 32'h1);
        chk("C_noack_a", 32'(ack1), 32'h0);
        tick();
        chk("C_busy_b", 32'(busy1), 32'h0);
        chk("C_noack_b", 32'(ack1), 32'h0);
        tick();
        chk("C_ack", 32'(ack1), 32'h2);
        chk("C_d1",  32'(rnd1), 32'(s3[15:0]));

        // Seed load of zero while requester 1 is active.
        tick();
        tick();
        seed_in   = 32'h0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("D_noack0", 32'(ack0), 32'h0);
        chk("D_noack1", 32'(ack1), 32'h0);
        chk("D_busy1",  32'(busy1), 32'h1);
        tick();
        chk("D_ack",    32'(ack0), 32'h2);
        chk("D_d1",     32'(rnd0), 32'h2021);
        tick();
        tick();
        chk("D_d2",     32'(rnd0), 32'h0601);

        // Requester 2 withdraws just before its turn.
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        req   = 4'b1011;
        seen0 = 4'b0000;
        tick();
        chk("E_skip", 32'(ack0), 32'h8);
        for (int i = 0; i < 6; i++) tick();
        chk("E_no2", 32'(seen0[2]), 32'h0);

        // Asynchronous reset while ack is high.
        do_reset();
        req = 4'b0001;
        tick();
        chk("F_pre", 32'(ack0), 32'h1);
        rst = 1'b1;
        #1;
        chk("F_async_ack", 32'(ack0), 32'h0);
        chk("F_async_rnd", 32'(rnd0), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("F_d1", 32'(rnd0), 32'h2021);

        // Random traffic with occasional reseeds.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req       = 4'($urandom_range(0, 15));
            seed_load = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            tick();
        end
        seed_load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
